// File: rtl/hci_core_req_skid_if.sv
// HCI core link: request (req/gnt/payload) and response (r_*) channels.
// The master drives the request and consumes the response; the slave does the opposite.
interface hci_core_intf #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned BW = 8,
   parameter int unsigned UW = 1,
   parameter int unsigned OW = 1
) ();
   logic                 req;
   logic                 gnt;
   logic [AW-1:0]        add;
   logic                 we_n;
   logic [DW-1:0]        data;
   logic [DW/BW-1:0]     be;
   logic [15:0]          boffs;
   logic [DW/BW-1:0]     lrdy;
   logic [UW-1:0]        user;
   logic [DW-1:0]        r_data;
   logic                 r_valid;
   logic [OW-1:0]        r_opc;
   logic [UW-1:0]        r_user;

   // Handshake: a request transfers on a cycle where req & gnt are both high.
   // The master keeps req and payload stable until gnt; gnt may be high at any time.
   modport master (
      output req, add, we_n, data, be, boffs, lrdy, user,
      input  gnt, r_data, r_valid, r_opc, r_user
   );

   modport slave (
      input  req, add, we_n, data, be, boffs, lrdy, user,
      output gnt, r_data, r_valid, r_opc, r_user
   );
endinterface

// File: rtl/hci_core_req_skid.sv
// Two-entry skid buffer on the HCI request channel; gnt upstream comes from flops only.
// Define HCI_CORE_SKID_RESP_REG_EN to register the response channel (+1 cycle).
module hci_core_req_skid #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned BW = 8,
   parameter int unsigned UW = 1,
   parameter int unsigned OW = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   hci_core_intf.slave  tcdm_slave,
   hci_core_intf.master tcdm_master,
   output logic         full_o
);
   localparam int unsigned BEW = DW / BW;

   typedef struct packed {
      logic [AW-1:0]  add;
      logic           we_n;
      logic [DW-1:0]  data;
      logic [BEW-1:0] be;
      logic [15:0]    boffs;
      logic [BEW-1:0] lrdy;
      logic [UW-1:0]  user;
   } entry_t;

   entry_t     mem_q [2];
   entry_t     wr_entry;
   entry_t     rd_entry;
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic       last_ptr_q;
   logic [1:0] cnt_q;
   logic       push;
   logic       pop;
   logic       show_ptr;

   assign tcdm_slave.gnt  = (cnt_q != 2'd2);
   assign tcdm_master.req = (cnt_q != 2'd0);
   assign full_o          = (cnt_q == 2'd2);

   assign push = tcdm_slave.req & tcdm_slave.gnt;
   assign pop  = tcdm_master.req & tcdm_master.gnt;

   // When empty, keep showing the entry that was last presented so the payload holds.
   assign show_ptr = (cnt_q != 2'd0) ? rd_ptr_q : last_ptr_q;
   assign rd_entry = mem_q[show_ptr];

   assign wr_entry.add   = tcdm_slave.add;
   assign wr_entry.we_n  = tcdm_slave.we_n;
   assign wr_entry.data  = tcdm_slave.data;
   assign wr_entry.be    = tcdm_slave.be;
   assign wr_entry.boffs = tcdm_slave.boffs;
   assign wr_entry.lrdy  = tcdm_slave.lrdy;
   assign wr_entry.user  = tcdm_slave.user;

   assign tcdm_master.add   = rd_entry.add;
   assign tcdm_master.we_n  = rd_entry.we_n;
   assign tcdm_master.data  = rd_entry.data;
   assign tcdm_master.be    = rd_entry.be;
   assign tcdm_master.boffs = rd_entry.boffs;
   assign tcdm_master.lrdy  = rd_entry.lrdy;
   assign tcdm_master.user  = rd_entry.user;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         last_ptr_q <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else if (clear_i) begin
         // Flush wins over push/pop; storage is left as is.
         cnt_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         last_ptr_q <= show_ptr;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q   <= ~rd_ptr_q;
            last_ptr_q <= rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   logic [DW-1:0] rsp_data;
   logic          rsp_valid;
   logic [OW-1:0] rsp_opc;
   logic [UW-1:0] rsp_user;

`ifdef HCI_CORE_SKID_RESP_REG_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
         rsp_opc   <= '0;
         rsp_user  <= '0;
      end else begin
         rsp_valid <= clear_i ? 1'b0 : tcdm_master.r_valid;
         if (tcdm_master.r_valid) begin
            rsp_data <= tcdm_master.r_data;
            rsp_opc  <= tcdm_master.r_opc;
            rsp_user <= tcdm_master.r_user;
         end
      end
   end
`else
   assign rsp_data  = tcdm_master.r_data;
   assign rsp_valid = tcdm_master.r_valid;
   assign rsp_opc   = tcdm_master.r_opc;
   assign rsp_user  = tcdm_master.r_user;
`endif

   assign tcdm_slave.r_data  = rsp_data;
   assign tcdm_slave.r_valid = rsp_valid;
   assign tcdm_slave.r_opc   = rsp_opc;
   assign tcdm_slave.r_user  = rsp_user;
endmodule

// File: tb/tb_hci_core_req_skid.sv
// Bench for hci_core_req_skid: queue-based reference of the 2-slot FIFO plus directed literals.
`timescale 1ns/1ps
module tb_hci_core_req_skid;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BW  = 8;
   localparam int UW  = 1;
   localparam int OW  = 1;
   localparam int BEW = DW / BW;
   localparam int W   = AW + 1 + DW + BEW + 16 + BEW + UW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic full;

   hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW), .OW(OW)) s_if ();
   hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW), .OW(OW)) m_if ();

   hci_core_req_skid #(.DW(DW), .AW(AW), .BW(BW), .UW(UW), .OW(OW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .tcdm_slave  (s_if),
      .tcdm_master (m_if),
      .full_o      (full)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int pop_count   = 0;
   bit chk_en      = 1'b0;

   // Reference: the buffer is an ordered queue of at most two requests.
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  last_shown = '0;
   logic [DW-1:0] rsp_data_m  = '0;
   logic          rsp_valid_m = 1'b0;
   logic [OW-1:0] rsp_opc_m   = '0;
   logic [UW-1:0] rsp_user_m  = '0;

   function automatic logic [W-1:0] s_pack();
      return {s_if.add, s_if.we_n, s_if.data, s_if.be, s_if.boffs, s_if.lrdy, s_if.user};
   endfunction

   function automatic logic [W-1:0] m_pack();
      return {m_if.add, m_if.we_n, m_if.data, m_if.be, m_if.boffs, m_if.lrdy, m_if.user};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference update on each active edge.
   always @(posedge clk) begin
      if (rst_n) begin
         bit push_m;
         bit pop_m;
         push_m = s_if.req && (exp_q.size() != 2);
         pop_m  = (exp_q.size() != 0) && m_if.gnt;
         if (pop_m) pop_count++;
         if (clear) exp_q.delete();
         else begin
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(s_pack());
         end
`ifdef HCI_CORE_SKID_RESP_REG_EN
         rsp_valid_m = clear ? 1'b0 : m_if.r_valid;
         if (m_if.r_valid) begin
            rsp_data_m = m_if.r_data;
            rsp_opc_m  = m_if.r_opc;
            rsp_user_m = m_if.r_user;
         end
`endif
      end
   end

   // Compare on the falling edge, every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [W-1:0] exp_pl;
         exp_pl = (exp_q.size() != 0) ? exp_q[0] : last_shown;
         last_shown = exp_pl;
         check("slave_gnt", s_if.gnt, exp_q.size() != 2);
         check("master_req", m_if.req, exp_q.size() != 0);
         check("full", full, exp_q.size() == 2);
         check("payload", m_pack(), exp_pl);
`ifdef HCI_CORE_SKID_RESP_REG_EN
         check("r_valid", s_if.r_valid, rsp_valid_m);
         check("r_data", s_if.r_data, rsp_data_m);
         check("r_opc", s_if.r_opc, rsp_opc_m);
         check("r_user", s_if.r_user, rsp_user_m);
`else
         check("r_valid", s_if.r_valid, m_if.r_valid);
         check("r_data", s_if.r_data, m_if.r_data);
         check("r_opc", s_if.r_opc, m_if.r_opc);
         check("r_user", s_if.r_user, m_if.r_user);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                          input logic [BEW-1:0] b);
      s_if.req   = 1'b1;
      s_if.add   = a;
      s_if.we_n  = we;
      s_if.data  = d;
      s_if.be    = b;
      s_if.boffs = '0;
      s_if.lrdy  = '1;
      s_if.user  = '0;
   endtask

   // Issue one request and wait (bounded) for it to be granted.
   task automatic send(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                       input logic [BEW-1:0] b);
      bit acc;
      bit ok;
      ok = 1'b0;
      set_req(a, we, d, b);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         acc = s_if.gnt;
         step();
         ok = acc;
      end
      s_if.req = 1'b0;
      check("send_accepted", ok, 1'b1);
   endtask

   initial begin
      int pc0;
      bit acc;
      s_if.req = 1'b0; s_if.add = '0; s_if.we_n = 1'b0; s_if.data = '0;
      s_if.be = '0; s_if.boffs = '0; s_if.lrdy = '0; s_if.user = '0;
      m_if.gnt = 1'b0; m_if.r_data = '0; m_if.r_valid = 1'b0; m_if.r_opc = '0; m_if.r_user = '0;

      // Reset values
      #3;
      check("rst_gnt", s_if.gnt, 1'b1);
      check("rst_req", m_if.req, 1'b0);
      check("rst_full", full, 1'b0);
      check("rst_r_valid", s_if.r_valid, 1'b0);
      check("rst_payload", m_pack(), '0);
      @(negedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step();

      // Single write, one cycle latency
      m_if.gnt = 1'b1;
      send(32'h100, 1'b0, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      check("wr_req", m_if.req, 1'b1);
      check("wr_add", m_if.add, 32'h100);
      check("wr_data", m_if.data, 32'hDEADBEEF);
      check("wr_be", m_if.be, 4'hF);
      step();
      @(negedge clk);
      check("wr_drained", m_if.req, 1'b0);
      check("wr_hold_add", m_if.add, 32'h100);
      step();

      // Fill to two with downstream stalled, third request blocked
      m_if.gnt = 1'b0;
      send(32'h0, 1'b1, '0, 4'hF);
      send(32'h4, 1'b1, '0, 4'hF);
      set_req(32'h8, 1'b1, '0, 4'hF);
      @(negedge clk);
      check("fill_full", full, 1'b1);
      check("fill_gnt", s_if.gnt, 1'b0);
      check("fill_head", m_if.add, 32'h0);
      step();
      m_if.gnt = 1'b1;
      @(negedge clk);
      check("order_0", m_if.add, 32'h0);
      step();
      @(negedge clk);
      check("order_4", m_if.add, 32'h4);
      check("order_gnt", s_if.gnt, 1'b1);
      step();
      s_if.req = 1'b0;
      @(negedge clk);
      check("order_8", m_if.add, 32'h8);
      step();

      // Streaming at one request per cycle
      pc0 = pop_count;
      for (int i = 0; i < 16; i++) begin
         set_req(32'h1000 + 32'(i * 4), 1'b1, 32'(i), 4'hF);
         @(negedge clk);
         if (i > 0) check("stream_add", m_if.add, 32'h1000 + 32'((i - 1) * 4));
         step();
      end
      s_if.req = 1'b0;
      step();
      @(negedge clk);
      check("stream_pops", 32'(pop_count - pc0), 32'd16);
      step();

      // Clear while full, concurrent request dropped
      m_if.gnt = 1'b0;
      send(32'h200, 1'b1, '0, 4'hF);
      send(32'h204, 1'b1, '0, 4'hF);
      set_req(32'h300, 1'b0, 32'hCAFE, 4'h3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      s_if.req = 1'b0;
      @(negedge clk);
      check("clr_req", m_if.req, 1'b0);
      check("clr_gnt", s_if.gnt, 1'b1);
      check("clr_full", full, 1'b0);
      step();
      m_if.gnt = 1'b1;
      @(negedge clk);
      check("clr_dropped", m_if.req, 1'b0);
      step();

      // Response path
      send(32'h40, 1'b1, '0, 4'hF);
      m_if.r_valid = 1'b1;
      m_if.r_data  = 32'h12345678;
      m_if.r_user  = 1'b1;
      @(negedge clk);
`ifndef HCI_CORE_SKID_RESP_REG_EN
      check("rsp_valid_now", s_if.r_valid, 1'b1);
      check("rsp_data_now", s_if.r_data, 32'h12345678);
`endif
      step();
      m_if.r_valid = 1'b0;
      m_if.r_data  = '0;
      m_if.r_user  = 1'b0;
      @(negedge clk);
`ifdef HCI_CORE_SKID_RESP_REG_EN
      check("rsp_valid_late", s_if.r_valid, 1'b1);
      check("rsp_data_late", s_if.r_data, 32'h12345678);
`else
      check("rsp_valid_gone", s_if.r_valid, 1'b0);
`endif
      step();

      // Random traffic with upstream hold-until-gnt behaviour
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = s_if.gnt;
         step();
         if (!s_if.req || acc) begin
            s_if.req   = ($urandom_range(0, 3) != 0);
            s_if.add   = $urandom;
            s_if.we_n  = 1'($urandom_range(0, 1));
            s_if.data  = $urandom;
            s_if.be    = 4'($urandom_range(0, 15));
            s_if.boffs = 16'($urandom);
            s_if.lrdy  = 4'($urandom_range(0, 15));
            s_if.user  = 1'($urandom_range(0, 1));
         end
         m_if.gnt     = ($urandom_range(0, 2) != 0);
         clear        = ($urandom_range(0, 31) == 0);
         m_if.r_valid = 1'($urandom_range(0, 1));
         m_if.r_data  = $urandom;
         m_if.r_opc   = 1'($urandom_range(0, 1));
         m_if.r_user  = 1'($urandom_range(0, 1));
      end
      clear    = 1'b0;
      s_if.req = 1'b0;
      step();
      @(negedge clk);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
